kmeans_centroid_update: RTL and testbench
=========================================

# kmeans_centroid_update

Responder-side K-means stage that recomputes every cluster centroid as the per-dimension mean of the points assigned to it. It sits under the Kmeans top FSM (the ST_CALC_CLUS step) and follows the same start_i/ready_o handshake as the other Kmeans sub-blocks. It masters the IO BRAM, which holds points and centroids, and the DC BRAM, which holds assignments, while the top FSM routes the BRAMs to it.

## Interface
Parameters:
- POINTS_BASE, 0: IO BRAM word address of point 0, dimension 0; points row-major, Num_Dims words per point
- CENT_BASE, 2048: IO BRAM word address of centroid 0, dimension 0; row-major
- ASSIGN_BASE, 0: DC BRAM word address of the assignment of point 0; one cluster index per word
- ACC_W, 32: accumulator and divider width

Ports:
- clk_i  in  1  single clock
- reset_n_i  in  1  asynchronous, active-low reset
- start_i  in  1  request from the top FSM
- ready_o  out  1  high when idle and able to accept start_i
- err_o  out  1  sticky error flag, cleared on accepted start
- IO_BRAM_addr_o  out  `IO_BRAM_ADDR_SIZE_BITS_NB  point read / centroid write address
- IO_BRAM_dout_o  out  `IO_BRAM_WORD_SIZE_BITS_NB  centroid write data, signed
- IO_BRAM_din_i  in  `IO_BRAM_WORD_SIZE_BITS_NB  point read data, signed
- IO_BRAM_we_o  out  1  IO BRAM write enable
- DC_BRAM_addr_o  out  `DC_BRAM_ADDR_SIZE_BITS_NB  assignment read address
- DC_BRAM_din_i  in  `DC_BRAM_WORD_SIZE_BITS_NB  assignment read data, unsigned
- Num_Vals_i, Num_Clusters_i, Num_Dims_i  in  `GPIO_WORD_SIZE_BITS_NB each  N, K, D; sampled on accepted start

## Operation
- Handshake:
  - start_i is accepted when start_i=1 and ready_o=1.
  - ready_o falls the next cycle and stays low until the job completes.
  - The initiator may hold start_i until ready_o falls; start_i is ignored while busy.
- Parameter check on accept:
  - If N=0, K=0 or D=0, set err_o, perform no BRAM access, and return to IDLE.
- Loop structure:
  - Outer loop: c from 0 to K-1. Inner loop: d from 0 to D-1. Point scan: p from 0 to N-1.
  - Per (c,d), clear acc and cnt before the scan.
  - For each p, read the assignment. If it equals c, read the point word and add it to acc (sign-extended), then increment cnt.
- Address generation uses no multiplier:
  - Point pointer starts at POINTS_BASE + d and adds D per p.
  - Centroid write pointer starts at CENT_BASE and increments once per (c,d), including skipped ones.
- Out-of-range assignment (value ≥ K): set err_o, treat the point as unmatched, and continue.
- End of scan:
  - cnt=0: no write; the old centroid stays in place.
  - Otherwise: signed divide acc/cnt, truncating toward zero; write the low word to the centroid pointer with we=1 for one cycle.
- Quotient range: the quotient always fits the word width, because a mean lies within the range of the points.
- States: IDLE, CHECK, ASN_RD, ASN_CHK, PT_RD, PT_ACC, DIV, WRITE, NEXT, DONE.
  - IDLE→CHECK on accept.
  - CHECK→DONE on error, else →ASN_RD.
  - ASN_RD→ASN_CHK.
  - ASN_CHK→PT_RD on match, else →NEXT.
  - PT_RD→PT_ACC→NEXT.
  - NEXT advances p. At the end of the scan it goes to DIV if cnt≠0, else it advances (c,d). If (c,d) is exhausted it goes to DONE.
  - DIV→WRITE on divider done; WRITE advances (c,d).
  - DONE→IDLE with ready_o=1.

## Timing
- Reset values: ready_o=1, err_o=0, all addr=0, IO_BRAM_dout_o=0, IO_BRAM_we_o=0, all counters and FSM cleared.
- Reset mid-job aborts immediately. A partially updated centroid set is acceptable; no write is issued after reset assertion.
- BRAM reads are registered: din is valid the cycle after addr is presented.
- Per-point cost: 2 cycles unmatched, 4 cycles matched, plus 1 NEXT cycle.
- Divider: start pulse to done pulse is exactly ACC_W+1 cycles; WRITE takes 1 cycle.
- Done signalling: ready_o rises the cycle after DONE.
- The err_o value is stable when ready_o rises.
- IO_BRAM_we_o is high only in WRITE.

## Structure
- The shared Kmeans package holds:
  - the state enum
  - ACC_W
  - the memory-map base constants, alongside the existing `IO_BRAM_*/`DC_BRAM_*/`GPIO_* defines
- Sub-module: kmeans_seq_divider, a signed restoring divider.
  - Interface: start/done pulse, ACC_W-bit dividend and divisor.
  - Behaviour: truncates toward zero, fixed ACC_W+1 latency.

## Test plan
- N=4, D=1, K=2; points 2, 4, 10, 12; assignments 0, 0, 1, 1 → writes 3 @CENT_BASE and 11 @CENT_BASE+1; err_o=0; ready_o returns high.
- N=2, D=2, K=1; points (-3,5), (-4,6) → writes -3 and 5 (truncation toward zero), in address order.
- K=3 with no point assigned to cluster 1 → no write to CENT_BASE+1 and its preloaded value unchanged; clusters 0 and 2 updated.
- Num_Clusters_i=0 → ready_o back high within 3 cycles of accept, err_o=1, zero BRAM writes; the next valid start clears err_o.
- Assignment value 7 with K=2 → err_o=1, that point excluded from every mean, other centroids correct.
- reset_n_i asserted during DIV → outputs take their reset values asynchronously and the pending write never occurs; a fresh start then yields correct results.

Source files
------------

// File: rtl/kmeans_centroid_update_pkg.sv
// =============================================================================
// Module  : kmeans_centroid_update_pkg
// Brief   : Shared K-means types, widths and memory-map constants.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

`ifndef IO_BRAM_ADDR_SIZE_BITS_NB
`define IO_BRAM_ADDR_SIZE_BITS_NB 12
`endif
`ifndef IO_BRAM_WORD_SIZE_BITS_NB
`define IO_BRAM_WORD_SIZE_BITS_NB 16
`endif
`ifndef DC_BRAM_ADDR_SIZE_BITS_NB
`define DC_BRAM_ADDR_SIZE_BITS_NB 12
`endif
`ifndef DC_BRAM_WORD_SIZE_BITS_NB
`define DC_BRAM_WORD_SIZE_BITS_NB 16
`endif
`ifndef GPIO_WORD_SIZE_BITS_NB
`define GPIO_WORD_SIZE_BITS_NB 32
`endif

package kmeans_centroid_update_pkg;

    localparam int unsigned IO_ADDR_W = `IO_BRAM_ADDR_SIZE_BITS_NB;
    localparam int unsigned IO_W      = `IO_BRAM_WORD_SIZE_BITS_NB;
    localparam int unsigned DC_ADDR_W = `DC_BRAM_ADDR_SIZE_BITS_NB;
    localparam int unsigned DC_W      = `DC_BRAM_WORD_SIZE_BITS_NB;
    localparam int unsigned GPIO_W    = `GPIO_WORD_SIZE_BITS_NB;

    localparam int unsigned KM_ACC_W       = 32;
    localparam int unsigned KM_POINTS_BASE = 0;
    localparam int unsigned KM_CENT_BASE   = 2048;
    localparam int unsigned KM_ASSIGN_BASE = 0;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_CHECK   = 4'd1,
        ST_ASN_RD  = 4'd2,
        ST_ASN_CHK = 4'd3,
        ST_PT_RD   = 4'd4,
        ST_PT_ACC  = 4'd5,
        ST_DIV     = 4'd6,
        ST_WRITE   = 4'd7,
        ST_NEXT    = 4'd8,
        ST_DONE    = 4'd9
    } km_state_e;

endpackage

`default_nettype wire

// File: rtl/kmeans_seq_divider.sv
// =============================================================================
// Module  : kmeans_seq_divider
// Brief   : Signed restoring divider, truncating toward zero, ACC_W+1 latency.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module kmeans_seq_divider #(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned Q_W   = 16
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic [ACC_W-1:0] dividend_i,
    input  logic [ACC_W-1:0] divisor_i,
    output logic             done_o,
    output logic [Q_W-1:0]   quotient_o
);

    localparam int unsigned STEP_W = $clog2(ACC_W) + 1;

    logic              busy_q, busy_d;
    logic              neg_q, neg_d;
    logic              done_q, done_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [ACC_W-1:0]  rem_q, rem_d;
    logic [ACC_W-1:0]  quo_q, quo_d;
    logic [ACC_W-1:0]  dvs_q, dvs_d;
    logic [Q_W-1:0]    res_q, res_d;
    logic [ACC_W:0]    shifted;
    logic [ACC_W:0]    trial;
    logic [ACC_W-1:0]  quo_step;

    // Operands are reduced to magnitudes; the sign is restored on the final step.
    always_comb begin
        busy_d   = busy_q;
        neg_d    = neg_q;
        done_d   = 1'b0;
        step_d   = step_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        res_d    = res_q;
        shifted  = {rem_q, quo_q[ACC_W-1]};
        trial    = shifted - {1'b0, dvs_q};
        quo_step = {quo_q[ACC_W-2:0], ~trial[ACC_W]};
        if (start_i) begin
            busy_d = 1'b1;
            step_d = '0;
            rem_d  = '0;
            quo_d  = dividend_i[ACC_W-1] ? -dividend_i : dividend_i;
            dvs_d  = divisor_i[ACC_W-1]  ? -divisor_i  : divisor_i;
            neg_d  = dividend_i[ACC_W-1] ^ divisor_i[ACC_W-1];
        end else if (busy_q) begin
            rem_d  = trial[ACC_W] ? shifted[ACC_W-1:0] : trial[ACC_W-1:0];
            quo_d  = quo_step;
            step_d = step_q + STEP_W'(1);
            if (step_q == STEP_W'(ACC_W - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                res_d  = neg_q ? Q_W'(-quo_step) : Q_W'(quo_step);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            busy_q <= 1'b0;
            neg_q  <= 1'b0;
            done_q <= 1'b0;
            step_q <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            res_q  <= '0;
        end else begin
            busy_q <= busy_d;
            neg_q  <= neg_d;
            done_q <= done_d;
            step_q <= step_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            res_q  <= res_d;
        end
    end

    assign done_o     = done_q;
    assign quotient_o = res_q;

endmodule

`default_nettype wire

// File: rtl/kmeans_centroid_update.sv
// =============================================================================
// Module  : kmeans_centroid_update
// Brief   : Recomputes each centroid as the per-dimension mean of its points.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module kmeans_centroid_update
    import kmeans_centroid_update_pkg::*;
#(
    parameter int unsigned POINTS_BASE = KM_POINTS_BASE,
    parameter int unsigned CENT_BASE   = KM_CENT_BASE,
    parameter int unsigned ASSIGN_BASE = KM_ASSIGN_BASE,
    parameter int unsigned ACC_W       = KM_ACC_W
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 start_i,
    output logic                 ready_o,
    output logic                 err_o,
    output logic [IO_ADDR_W-1:0] IO_BRAM_addr_o,
    output logic [IO_W-1:0]      IO_BRAM_dout_o,
    input  logic [IO_W-1:0]      IO_BRAM_din_i,
    output logic                 IO_BRAM_we_o,
    output logic [DC_ADDR_W-1:0] DC_BRAM_addr_o,
    input  logic [DC_W-1:0]      DC_BRAM_din_i,
    input  logic [GPIO_W-1:0]    Num_Vals_i,
    input  logic [GPIO_W-1:0]    Num_Clusters_i,
    input  logic [GPIO_W-1:0]    Num_Dims_i
);

    km_state_e            state_q, state_d;
    logic                 err_q, err_d;
    logic [GPIO_W-1:0]    n_q, n_d, k_q, k_d, dims_q, dims_d;
    logic [GPIO_W-1:0]    c_q, c_d, d_q, d_d, p_q, p_d, cnt_q, cnt_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [IO_ADDR_W-1:0] pt_ptr_q, pt_ptr_d, cent_ptr_q, cent_ptr_d;
    logic [IO_ADDR_W-1:0] io_addr_q, io_addr_d;
    logic [IO_W-1:0]      io_dout_q, io_dout_d;
    logic                 io_we_q, io_we_d;
    logic [DC_ADDR_W-1:0] dc_addr_q, dc_addr_d;
    logic [GPIO_W-1:0]    asn;
    logic                 advance;
    logic                 div_start, div_done;
    logic [IO_W-1:0]      div_quot;

    kmeans_seq_divider #(
        .ACC_W(ACC_W),
        .Q_W  (IO_W)
    ) u_div (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .start_i   (div_start),
        .dividend_i(acc_q),
        .divisor_i (ACC_W'(cnt_q)),
        .done_o    (div_done),
        .quotient_o(div_quot)
    );

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        n_d        = n_q;
        k_d        = k_q;
        dims_d     = dims_q;
        c_d        = c_q;
        d_d        = d_q;
        p_d        = p_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        pt_ptr_d   = pt_ptr_q;
        cent_ptr_d = cent_ptr_q;
        io_addr_d  = io_addr_q;
        io_dout_d  = io_dout_q;
        io_we_d    = 1'b0;
        dc_addr_d  = dc_addr_q;
        advance    = 1'b0;
        div_start  = 1'b0;
        asn        = GPIO_W'(DC_BRAM_din_i);

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    n_d     = Num_Vals_i;
                    k_d     = Num_Clusters_i;
                    dims_d  = Num_Dims_i;
                    err_d   = 1'b0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (n_q == '0 || k_q == '0 || dims_q == '0) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    c_d        = '0;
                    d_d        = '0;
                    p_d        = '0;
                    cnt_d      = '0;
                    acc_d      = '0;
                    pt_ptr_d   = IO_ADDR_W'(POINTS_BASE);
                    cent_ptr_d = IO_ADDR_W'(CENT_BASE);
                    dc_addr_d  = DC_ADDR_W'(ASSIGN_BASE);
                    state_d    = ST_ASN_RD;
                end
            end
            ST_ASN_RD:  state_d = ST_ASN_CHK;
            ST_ASN_CHK: begin
                if (asn >= k_q) begin
                    err_d   = 1'b1;
                    state_d = ST_NEXT;
                end else if (asn == c_q) begin
                    io_addr_d = pt_ptr_q;
                    state_d   = ST_PT_RD;
                end else begin
                    state_d = ST_NEXT;
                end
            end
            ST_PT_RD:  state_d = ST_PT_ACC;
            ST_PT_ACC: begin
                acc_d   = acc_q + {{(ACC_W-IO_W){IO_BRAM_din_i[IO_W-1]}}, IO_BRAM_din_i};
                cnt_d   = cnt_q + 1;
                state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (p_q == n_q - 1) begin
                    if (cnt_q != '0) begin
                        div_start = 1'b1;
                        state_d   = ST_DIV;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    p_d       = p_q + 1;
                    pt_ptr_d  = pt_ptr_q + IO_ADDR_W'(dims_q);
                    dc_addr_d = dc_addr_q + DC_ADDR_W'(1);
                    state_d   = ST_ASN_RD;
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    io_addr_d = cent_ptr_q;
                    io_dout_d = div_quot;
                    io_we_d   = 1'b1;
                    state_d   = ST_WRITE;
                end
            end
            ST_WRITE: advance = 1'b1;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Step to the next (c,d) pair; the centroid pointer moves even when no write happened.
        if (advance) begin
            cent_ptr_d = cent_ptr_q + IO_ADDR_W'(1);
            p_d        = '0;
            cnt_d      = '0;
            acc_d      = '0;
            dc_addr_d  = DC_ADDR_W'(ASSIGN_BASE);
            state_d    = ST_ASN_RD;
            if (d_q == dims_q - 1) begin
                d_d      = '0;
                pt_ptr_d = IO_ADDR_W'(POINTS_BASE);
                if (c_q == k_q - 1) begin
                    state_d = ST_DONE;
                end else begin
                    c_d = c_q + 1;
                end
            end else begin
                d_d      = d_q + 1;
                pt_ptr_d = IO_ADDR_W'(POINTS_BASE) + IO_ADDR_W'(d_q + 1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_IDLE;
            err_q      <= 1'b0;
            n_q        <= '0;
            k_q        <= '0;
            dims_q     <= '0;
            c_q        <= '0;
            d_q        <= '0;
            p_q        <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            pt_ptr_q   <= '0;
            cent_ptr_q <= '0;
            io_addr_q  <= '0;
            io_dout_q  <= '0;
            io_we_q    <= 1'b0;
            dc_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            n_q        <= n_d;
            k_q        <= k_d;
            dims_q     <= dims_d;
            c_q        <= c_d;
            d_q        <= d_d;
            p_q        <= p_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            pt_ptr_q   <= pt_ptr_d;
            cent_ptr_q <= cent_ptr_d;
            io_addr_q  <= io_addr_d;
            io_dout_q  <= io_dout_d;
            io_we_q    <= io_we_d;
            dc_addr_q  <= dc_addr_d;
        end
    end

    assign ready_o        = (state_q == ST_IDLE);
    assign err_o          = err_q;
    assign IO_BRAM_addr_o = io_addr_q;
    assign IO_BRAM_dout_o = io_dout_q;
    assign IO_BRAM_we_o   = io_we_q;
    assign DC_BRAM_addr_o = dc_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_kmeans_centroid_update.sv
// =============================================================================
// Module  : tb_kmeans_centroid_update
// Brief   : Directed self-checking bench for kmeans_centroid_update.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_kmeans_centroid_update;
    import kmeans_centroid_update_pkg::*;

    localparam int unsigned MEM_D = 1 << IO_ADDR_W;
    localparam int unsigned DC_D  = 1 << DC_ADDR_W;
    localparam int unsigned CB    = KM_CENT_BASE;

    logic                 clk_i = 1'b0;
    logic                 reset_n_i;
    logic                 start_i;
    logic                 ready_o;
    logic                 err_o;
    logic [IO_ADDR_W-1:0] io_addr;
    logic [IO_W-1:0]      io_dout;
    logic [IO_W-1:0]      io_din;
    logic                 io_we;
    logic [DC_ADDR_W-1:0] dc_addr;
    logic [DC_W-1:0]      dc_din;
    logic [GPIO_W-1:0]    num_vals, num_clusters, num_dims;

    logic signed [IO_W-1:0] io_mem [0:MEM_D-1];
    logic [DC_W-1:0]        dc_mem [0:DC_D-1];
    logic [IO_ADDR_W-1:0]   wr_addr [0:63];
    logic signed [IO_W-1:0] wr_data [0:63];
    int                     wr_n = 0;
    int                     checks = 0;
    int                     errors = 0;
    int                     base;
    int                     cyc;

    always #5 clk_i = ~clk_i;

    kmeans_centroid_update dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .start_i       (start_i),
        .ready_o       (ready_o),
        .err_o         (err_o),
        .IO_BRAM_addr_o(io_addr),
        .IO_BRAM_dout_o(io_dout),
        .IO_BRAM_din_i (io_din),
        .IO_BRAM_we_o  (io_we),
        .DC_BRAM_addr_o(dc_addr),
        .DC_BRAM_din_i (dc_din),
        .Num_Vals_i    (num_vals),
        .Num_Clusters_i(num_clusters),
        .Num_Dims_i    (num_dims)
    );

    // Registered-read BRAM models; DUT writes are only logged.
    always @(posedge clk_i) begin
        io_din <= io_mem[io_addr];
        dc_din <= dc_mem[dc_addr];
        if (io_we && wr_n < 64) begin
            wr_addr[wr_n] <= io_addr;
            wr_data[wr_n] <= io_dout;
            wr_n          <= wr_n + 1;
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_job(input int n, input int k, input int d);
        @(negedge clk_i);
        num_vals     = GPIO_W'(n);
        num_clusters = GPIO_W'(k);
        num_dims     = GPIO_W'(d);
        start_i      = 1'b1;
        base         = wr_n;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        cyc = 0;
        while (!ready_o && cyc < 3000) begin
            @(negedge clk_i);
            cyc++;
        end
        chk(tag, 32'(ready_o), 1);
    endtask

    task automatic chk_wr(input string tag, input int idx, input int addr, input int data);
        chk({tag, "_addr"}, 32'(wr_addr[base+idx]), addr);
        chk({tag, "_data"}, 32'(wr_data[base+idx]), data);
    endtask

    task automatic load_1d(input int p0, input int p1, input int p2, input int p3,
                           input int a0, input int a1, input int a2, input int a3);
        io_mem[0] = IO_W'(p0); io_mem[1] = IO_W'(p1);
        io_mem[2] = IO_W'(p2); io_mem[3] = IO_W'(p3);
        dc_mem[0] = DC_W'(a0); dc_mem[1] = DC_W'(a1);
        dc_mem[2] = DC_W'(a2); dc_mem[3] = DC_W'(a3);
    endtask

    initial begin
        for (int i = 0; i < int'(MEM_D); i++) io_mem[i] = '0;
        for (int i = 0; i < int'(DC_D); i++) dc_mem[i] = '0;
        reset_n_i = 1'b0;
        start_i   = 1'b0;
        num_vals = '0; num_clusters = '0; num_dims = '0;
        #2;
        chk("rst_ready", 32'(ready_o), 1);
        chk("rst_err",   32'(err_o), 0);
        chk("rst_we",    32'(io_we), 0);
        chk("rst_ioaddr", 32'(io_addr), 0);
        chk("rst_dcaddr", 32'(dc_addr), 0);
        chk("rst_dout",  32'(io_dout), 0);
        repeat (3) @(negedge clk_i);
        reset_n_i = 1'b1;

        // Two 1-D clusters
        load_1d(2, 4, 10, 12, 0, 0, 1, 1);
        start_job(4, 2, 1);
        chk("t1_busy", 32'(ready_o), 0);
        wait_ready("t1_done");
        chk("t1_nwr", wr_n - base, 2);
        chk_wr("t1_w0", 0, CB, 3);
        chk_wr("t1_w1", 1, CB + 1, 11);
        chk("t1_err", 32'(err_o), 0);

        // Two dimensions, negative mean truncates toward zero
        load_1d(-3, 5, -4, 6, 0, 0, 0, 0);
        start_job(2, 1, 2);
        wait_ready("t2_done");
        chk("t2_nwr", wr_n - base, 2);
        chk_wr("t2_w0", 0, CB, -3);
        chk_wr("t2_w1", 1, CB + 1, 5);

        // Empty cluster 1 keeps its old centroid
        load_1d(1, 3, 20, 8, 0, 0, 2, 2);
        io_mem[CB+1] = 77;
        start_job(4, 3, 1);
        wait_ready("t3_done");
        chk("t3_nwr", wr_n - base, 2);
        chk_wr("t3_w0", 0, CB, 2);
        chk_wr("t3_w1", 1, CB + 2, 14);
        chk("t3_keep", 32'(io_mem[CB+1]), 77);

        // K=0 rejected quickly with no writes
        start_job(4, 0, 1);
        wait_ready("t4_done");
        chk("t4_lat", cyc + 1 <= 3 ? 1 : 0, 1);
        chk("t4_err", 32'(err_o), 1);
        chk("t4_nwr", wr_n - base, 0);
        load_1d(2, 4, 10, 12, 0, 0, 1, 1);
        start_job(4, 2, 1);
        wait_ready("t4b_done");
        chk("t4b_err", 32'(err_o), 0);
        chk_wr("t4b_w1", 1, CB + 1, 11);

        // Out-of-range assignment excluded from every mean
        load_1d(2, 4, 10, 100, 0, 0, 1, 7);
        start_job(4, 2, 1);
        wait_ready("t5_done");
        chk("t5_err", 32'(err_o), 1);
        chk("t5_nwr", wr_n - base, 2);
        chk_wr("t5_w0", 0, CB, 3);
        chk_wr("t5_w1", 1, CB + 1, 10);

        // Reset while the cluster-0 divide is in flight
        load_1d(2, 4, 10, 12, 0, 0, 1, 1);
        start_job(4, 2, 1);
        repeat (24) @(negedge clk_i);
        #1 reset_n_i = 1'b0;
        #1;
        chk("t6_ready", 32'(ready_o), 1);
        chk("t6_err",   32'(err_o), 0);
        chk("t6_we",    32'(io_we), 0);
        chk("t6_ioaddr", 32'(io_addr), 0);
        chk("t6_dout",  32'(io_dout), 0);
        repeat (3) @(negedge clk_i);
        reset_n_i = 1'b1;
        repeat (60) @(negedge clk_i);
        chk("t6_nowr", wr_n - base, 0);
        start_job(4, 2, 1);
        wait_ready("t6b_done");
        chk("t6b_nwr", wr_n - base, 2);
        chk_wr("t6b_w0", 0, CB, 3);
        chk_wr("t6b_w1", 1, CB + 1, 11);
        chk("t6b_err", 32'(err_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
